uart_rx: RTL and testbench

- Serial receive half of the UART. Converts the asynchronous `rx` line (8N1 format, LSB first) into a parallel byte plus a one-cycle `rx_ready` strobe.
- Its downstream consumer is the echo/control logic, which latches `rx_byte` on `rx_ready`.
- Mid-bit sampling with a configurable clock divider. Start-bit glitch rejection, framing-error reporting, and break (long-low) recovery.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel byte and status strobes out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_ready;
    logic                 rx_error;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_byte,
        output rx_ready,
        output rx_error,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_byte,
        input  rx_ready,
        input  rx_error,
        input  rx_busy
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error strobe and break recovery.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q,   state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] byte_q,    byte_d;
    logic                 ready_q,   ready_d;
    logic                 error_q,   error_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                // A start bit that is gone by mid-bit is treated as line noise.
                if (clk_cnt_q == HALF) begin
                    if (!rx_s) begin
                        clk_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    clk_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            BREAK: begin
                // Held-low line: wait for release so a long break yields a single error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign bus.rx_byte  = byte_q;
    assign bus.rx_ready = ready_q;
    assign bus.rx_error = error_q;
    assign bus.rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frame streams against a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    logic [7:0]  obs_q[$];
    int unsigned obs_err = 0;
    int unsigned last_ready_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every byte strobe and error strobe, and checks they never coincide.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_ready) begin
                obs_q.push_back(bus.rx_byte);
                last_ready_cyc = cyc;
            end
            if (bus.rx_error) obs_err++;
            if (bus.rx_ready || bus.rx_error) begin
                vectors++;
                if ((bus.rx_ready && bus.rx_error) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL exclusive: rx_ready=%b rx_error=%b, required not both high", bus.rx_ready, bus.rx_error);
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        bus.rx = 1'b1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_err = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (bus.rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h, expected 00", bus.rx_byte); end
        if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", bus.rx_ready); end
        if (bus.rx_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b, expected 0", bus.rx_error); end
        if (bus.rx_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", bus.rx_busy); end
        reset = 1'b0;
        idle(CPB);
        vectors++;
        if (bus.rx_busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, expected 0", bus.rx_busy); end
    endtask

    task automatic test_single();
        int unsigned start_cyc;
        int unsigned lat;
        logic [7:0] got;
        clear_obs();
        start_cyc = cyc;
        send_frame(8'h55, 1'b1);
        idle(2 * CPB);
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        lat = last_ready_cyc - start_cyc;
        vectors += 5;
        if (obs_q.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d, expected 1", obs_q.size()); end
        if (got !== 8'h55)       begin miscompares++; $display("FAIL single_byte: got %h, expected 55", got); end
        if (obs_err !== 0)       begin miscompares++; $display("FAIL single_err: got %0d, expected 0", obs_err); end
        if (bus.rx_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b, expected 0", bus.rx_busy); end
        // 2 sync + HALF + 9 bit periods from the start edge, plus drive/observe offset
        if (lat < 153 || lat > 157) begin miscompares++; $display("FAIL single_latency: got %0d cycles, expected 153..157", lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g0;
        logic [7:0] g1;
        clear_obs();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(2 * CPB);
        g0 = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        g1 = (obs_q.size() > 1) ? obs_q[1] : 8'hxx;
        vectors += 4;
        if (obs_q.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d, expected 2", obs_q.size()); end
        if (g0 !== 8'hA5)        begin miscompares++; $display("FAIL b2b_byte0: got %h, expected a5", g0); end
        if (g1 !== 8'h3C)        begin miscompares++; $display("FAIL b2b_byte1: got %h, expected 3c", g1); end
        if (obs_err !== 0)       begin miscompares++; $display("FAIL b2b_err: got %0d, expected 0", obs_err); end
    endtask

    task automatic test_framing();
        logic [7:0] got;
        clear_obs();
        send_frame(8'hFF, 1'b0);
        idle(2 * CPB);
        vectors += 3;
        if (obs_err !== 1)          begin miscompares++; $display("FAIL frame_err: got %0d, expected 1", obs_err); end
        if (obs_q.size() !== 0)     begin miscompares++; $display("FAIL frame_ready: got %0d, expected 0", obs_q.size()); end
        if (bus.rx_byte !== 8'h3C)  begin miscompares++; $display("FAIL frame_hold: got %h, expected 3c", bus.rx_byte); end
        clear_obs();
        send_frame(8'h81, 1'b1);
        idle(2 * CPB);
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        vectors += 2;
        if (got !== 8'h81 || obs_q.size() !== 1) begin miscompares++; $display("FAIL frame_recover: got %h (count %0d), expected 81 (count 1)", got, obs_q.size()); end
        if (obs_err !== 0)          begin miscompares++; $display("FAIL frame_recover_err: got %0d, expected 0", obs_err); end
    endtask

    task automatic test_glitch();
        logic [7:0] got;
        clear_obs();
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * CPB);
        vectors += 3;
        if (obs_q.size() !== 0)    begin miscompares++; $display("FAIL glitch_ready: got %0d, expected 0", obs_q.size()); end
        if (obs_err !== 0)         begin miscompares++; $display("FAIL glitch_err: got %0d, expected 0", obs_err); end
        if (bus.rx_busy !== 1'b0)  begin miscompares++; $display("FAIL glitch_busy: got %b, expected 0", bus.rx_busy); end
        send_frame(8'h00, 1'b1);
        idle(2 * CPB);
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        vectors++;
        if (got !== 8'h00 || obs_q.size() !== 1) begin miscompares++; $display("FAIL glitch_next: got %h (count %0d), expected 00 (count 1)", got, obs_q.size()); end
    endtask

    task automatic test_break();
        logic [7:0] got;
        clear_obs();
        bus.rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        idle(2 * CPB);
        vectors += 3;
        if (obs_err !== 1)         begin miscompares++; $display("FAIL break_err: got %0d, expected 1", obs_err); end
        if (obs_q.size() !== 0)    begin miscompares++; $display("FAIL break_ready: got %0d, expected 0", obs_q.size()); end
        if (bus.rx_busy !== 1'b0)  begin miscompares++; $display("FAIL break_busy: got %b, expected 0", bus.rx_busy); end
        clear_obs();
        send_frame(8'h42, 1'b1);
        idle(2 * CPB);
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        vectors++;
        if (got !== 8'h42 || obs_q.size() !== 1 || obs_err !== 0) begin miscompares++; $display("FAIL break_next: got %h (count %0d, err %0d), expected 42 (count 1, err 0)", got, obs_q.size(), obs_err); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        clear_obs();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        bus.rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (bus.rx_byte !== 8'h00) begin miscompares++; $display("FAIL rstmid_byte: got %h, expected 00", bus.rx_byte); end
        if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: got %b, expected 0", bus.rx_ready); end
        if (bus.rx_error !== 1'b0) begin miscompares++; $display("FAIL rstmid_error: got %b, expected 0", bus.rx_error); end
        if (bus.rx_busy !== 1'b0)  begin miscompares++; $display("FAIL rstmid_busy: got %b, expected 0", bus.rx_busy); end
        reset = 1'b0;
        idle(CPB / 2 - 1 + 5 * CPB + 2 * CPB);
        vectors++;
        if (obs_q.size() !== 0 || obs_err !== 0) begin miscompares++; $display("FAIL rstmid_quiet: got %0d ready %0d error, expected 0 and 0", obs_q.size(), obs_err); end
        send_frame(8'hC3, 1'b1);
        idle(2 * CPB);
        got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
        vectors++;
        if (got !== 8'hC3 || obs_q.size() !== 1) begin miscompares++; $display("FAIL rstmid_next: got %h (count %0d), expected c3 (count 1)", got, obs_q.size()); end
    endtask

    // Frame-level reference: good stop bit delivers the byte, low stop bit costs one error and no byte.
    task automatic test_random();
        logic [7:0]  exp_q[$];
        int unsigned exp_err = 0;
        logic [7:0]  d;
        logic        stop;
        logic [7:0]  got;
        clear_obs();
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop);
            if (stop) begin
                exp_q.push_back(d);
                idle($urandom_range(0, CPB));
            end else begin
                exp_err++;
                idle(CPB + $urandom_range(0, CPB));
            end
        end
        idle(2 * CPB);
        vectors += 2;
        if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        if (obs_err !== exp_err)            begin miscompares++; $display("FAIL rand_err: got %0d, expected %0d", obs_err, exp_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte[%0d]: got %h, expected %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_break();
        test_reset_mid();
        test_random();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
